// File: rtl/sram_responder_if.sv
// sram_responder_if: active-low SRAM strobe bus between the LC-3 datapath and its memory responder.
interface sram_responder_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic              Mem_CE;
   logic              Mem_OE;
   logic              Mem_WE;
   logic              Mem_UB;
   logic              Mem_LB;
   logic [ADDR_W-1:0] ADDR;
   logic [DATA_W-1:0] Data_to_SRAM;
   logic [15:0]       Switches;
   logic [DATA_W-1:0] Data_from_SRAM;
   logic              Data_valid;
   logic              Busy;
   logic [15:0]       HEX_out;
   logic              Err;
   modport master (
      output Mem_CE, Mem_OE, Mem_WE, Mem_UB, Mem_LB, ADDR, Data_to_SRAM, Switches,
      input  Data_from_SRAM, Data_valid, Busy, HEX_out, Err
   );
   modport slave (
      input  Mem_CE, Mem_OE, Mem_WE, Mem_UB, Mem_LB, ADDR, Data_to_SRAM, Switches,
      output Data_from_SRAM, Data_valid, Busy, HEX_out, Err
   );
endinterface

// File: rtl/sram_responder.sv
// sram_responder: multi-cycle SRAM read/write responder with byte lanes and a memory-mapped switch/hex word.
module sram_responder #(
   parameter int              ADDR_W  = 16,
   parameter int              DATA_W  = 16,
   parameter int              DEPTH_W = 10,
   parameter int              RD_LAT  = 2,
   parameter int              WR_LAT  = 2,
   parameter logic [ADDR_W-1:0] IO_ADDR = 16'hFFFF
) (
   input logic Clk,
   input logic Reset,
   sram_responder_if.slave bus
);
   localparam int CNT_W = $clog2((RD_LAT > WR_LAT ? RD_LAT : WR_LAT) + 1);
   typedef enum logic [2:0] {IDLE, RD_WAIT, RD_HOLD, WR_WAIT, WR_HOLD} state_t;
   state_t              r_state, w_state_nx;
   logic [CNT_W-1:0]    r_cnt, w_cnt_nx, w_cnt_inc;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_rdata;
   logic [DATA_W-1:0]   r_mem [2**DEPTH_W];
   logic [15:0]         r_hex;
   logic                r_err;
   logic                w_rd, w_wr, w_bad, w_same, w_io, w_rd_go, w_wr_go, w_load, w_commit;
   logic [DEPTH_W-1:0]  w_idx;
   assign w_rd   = !bus.Mem_CE && !bus.Mem_OE && bus.Mem_WE;
   assign w_wr   = !bus.Mem_CE && !bus.Mem_WE && bus.Mem_OE;
   assign w_bad  = !bus.Mem_CE && !bus.Mem_OE && !bus.Mem_WE;
   assign w_same = bus.ADDR == r_addr;
   assign w_io   = bus.ADDR == IO_ADDR;
   assign w_idx  = bus.ADDR[DEPTH_W-1:0];
   // The strobe cycle seen in IDLE counts as the first, so short latencies finish straight from IDLE.
   always_comb begin
      w_rd_go    = w_rd && (r_state == IDLE || r_state == RD_WAIT);
      w_wr_go    = w_wr && (r_state == IDLE || (r_state == WR_WAIT && w_same));
      w_cnt_inc  = (r_state == IDLE || !w_same) ? CNT_W'(1) : r_cnt + 1'b1;
      w_load     = w_rd_go && w_cnt_inc == CNT_W'(RD_LAT - 1);
      w_commit   = w_wr_go && w_cnt_inc == CNT_W'(WR_LAT);
      w_cnt_nx   = (w_rd_go || w_wr_go) ? w_cnt_inc : r_cnt;
      w_state_nx = w_load                         ? RD_HOLD :
                   w_commit                       ? WR_HOLD :
                   w_rd_go                        ? RD_WAIT :
                   w_wr_go                        ? WR_WAIT :
                   (r_state == RD_HOLD && w_rd)   ? RD_HOLD :
                   (r_state == WR_HOLD && w_wr)   ? WR_HOLD : IDLE;
   end
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_addr  <= '0;
         r_rdata <= '0;
         r_hex   <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
         r_err   <= w_bad;
         if (w_rd_go || w_wr_go) r_addr <= bus.ADDR;
         if (w_load) r_rdata <= w_io ? bus.Switches : r_mem[w_idx];
         if (w_commit && w_io && !bus.Mem_UB) r_hex[15:8] <= bus.Data_to_SRAM[15:8];
         if (w_commit && w_io && !bus.Mem_LB) r_hex[7:0] <= bus.Data_to_SRAM[7:0];
      end
   end
   // Array contents survive reset; only the commit itself is suppressed while Reset is high.
   always_ff @(posedge Clk) begin
      if (!Reset && w_commit && !w_io && !bus.Mem_UB) r_mem[w_idx][15:8] <= bus.Data_to_SRAM[15:8];
      if (!Reset && w_commit && !w_io && !bus.Mem_LB) r_mem[w_idx][7:0] <= bus.Data_to_SRAM[7:0];
   end
   assign bus.Data_from_SRAM = r_rdata;
   assign bus.Data_valid     = r_state == RD_HOLD;
   assign bus.Busy           = r_state == RD_WAIT || r_state == WR_WAIT;
   assign bus.HEX_out        = r_hex;
   assign bus.Err            = r_err;
endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: directed vectors for the default responder plus a RD_LAT=3/WR_LAT=1 instance.
module tb_sram_responder;
   typedef enum logic [2:0] {OP_I, OP_R, OP_W, OP_WL, OP_B} op_t;
   typedef struct {
      logic        rst;
      op_t         op;
      logic [15:0] a;
      logic [15:0] d;
      logic [15:0] e_rd;
      logic [2:0]  e_vbe;
      logic [15:0] e_hex;
   } vec_t;
   logic Clk = 1'b0;
   logic Reset;
   int   n_chk = 0;
   int   n_err = 0;
   vec_t tv[$];
   logic [15:0] mdr, ir;
   sram_responder_if bus();
   sram_responder_if bus2();
   sram_responder dut (.Clk(Clk), .Reset(Reset), .bus(bus));
   sram_responder #(.RD_LAT(3), .WR_LAT(1)) dut2 (.Clk(Clk), .Reset(Reset), .bus(bus2));
   always #5 Clk = ~Clk;
   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic step(input logic rst, input op_t op, input logic [15:0] a, input logic [15:0] d);
      logic ce, oe, we, ub;
      ce = op == OP_I;
      oe = !(op == OP_R || op == OP_B);
      we = !(op == OP_W || op == OP_WL || op == OP_B);
      ub = op == OP_WL;
      @(negedge Clk);
      Reset = rst;
      bus.Mem_CE = ce;  bus.Mem_OE = oe;  bus.Mem_WE = we;  bus.Mem_UB = ub;  bus.Mem_LB = 1'b0;
      bus.ADDR = a;     bus.Data_to_SRAM = d;
      bus2.Mem_CE = ce; bus2.Mem_OE = oe; bus2.Mem_WE = we; bus2.Mem_UB = ub; bus2.Mem_LB = 1'b0;
      bus2.ADDR = a;    bus2.Data_to_SRAM = d;
      @(posedge Clk);
      #1;
   endtask
   task automatic add(input logic rst, input op_t op, input logic [15:0] a, input logic [15:0] d,
                      input logic [15:0] e_rd, input logic [2:0] e_vbe, input logic [15:0] e_hex);
      tv.push_back('{rst, op, a, d, e_rd, e_vbe, e_hex});
   endtask
   initial begin
      Reset = 1'b1;
      bus.Mem_CE = 1'b1;  bus.Mem_OE = 1'b1;  bus.Mem_WE = 1'b1;  bus.Mem_UB = 1'b1;  bus.Mem_LB = 1'b1;
      bus.ADDR = '0;      bus.Data_to_SRAM = '0; bus.Switches = 16'h00A5;
      bus2.Mem_CE = 1'b1; bus2.Mem_OE = 1'b1; bus2.Mem_WE = 1'b1; bus2.Mem_UB = 1'b1; bus2.Mem_LB = 1'b1;
      bus2.ADDR = '0;     bus2.Data_to_SRAM = '0; bus2.Switches = 16'h00A5;
      // expectations are the outputs just after the edge ending each cycle; e_vbe = {valid, busy, err}
      add(1, OP_I,  16'h0000, 16'h0000, 16'h0000, 3'b000, 16'h0000);
      add(0, OP_W,  16'h0020, 16'h1111, 16'h0000, 3'b010, 16'h0000);
      add(0, OP_W,  16'h0020, 16'h1111, 16'h0000, 3'b000, 16'h0000);
      add(0, OP_I,  16'h0000, 16'h0000, 16'h0000, 3'b000, 16'h0000);
      add(0, OP_W,  16'h0030, 16'h3030, 16'h0000, 3'b010, 16'h0000);
      add(0, OP_W,  16'h0030, 16'h3030, 16'h0000, 3'b000, 16'h0000);
      add(0, OP_I,  16'h0000, 16'h0000, 16'h0000, 3'b000, 16'h0000);
      add(0, OP_W,  16'h03FF, 16'h5A5A, 16'h0000, 3'b010, 16'h0000);
      add(0, OP_W,  16'h03FF, 16'h5A5A, 16'h0000, 3'b000, 16'h0000);
      add(0, OP_I,  16'h0000, 16'h0000, 16'h0000, 3'b000, 16'h0000);
      add(0, OP_W,  16'h0050, 16'h0505, 16'h0000, 3'b010, 16'h0000);
      add(0, OP_W,  16'h0050, 16'h0505, 16'h0000, 3'b000, 16'h0000);
      add(0, OP_I,  16'h0000, 16'h0000, 16'h0000, 3'b000, 16'h0000);
      add(0, OP_W,  16'h0010, 16'hBEEF, 16'h0000, 3'b010, 16'h0000);
      add(0, OP_W,  16'h0010, 16'hBEEF, 16'h0000, 3'b000, 16'h0000);
      add(0, OP_I,  16'h0000, 16'h0000, 16'h0000, 3'b000, 16'h0000);
      add(0, OP_R,  16'h0010, 16'h0000, 16'hBEEF, 3'b100, 16'h0000);
      add(0, OP_R,  16'h0010, 16'h0000, 16'hBEEF, 3'b100, 16'h0000);
      add(0, OP_I,  16'h0000, 16'h0000, 16'hBEEF, 3'b000, 16'h0000);
      add(0, OP_WL, 16'h0010, 16'h1234, 16'hBEEF, 3'b010, 16'h0000);
      add(0, OP_WL, 16'h0010, 16'h1234, 16'hBEEF, 3'b000, 16'h0000);
      add(0, OP_I,  16'h0000, 16'h0000, 16'hBEEF, 3'b000, 16'h0000);
      add(0, OP_R,  16'h0010, 16'h0000, 16'hBE34, 3'b100, 16'h0000);
      add(0, OP_I,  16'h0000, 16'h0000, 16'hBE34, 3'b000, 16'h0000);
      add(0, OP_W,  16'h0010, 16'h0000, 16'hBE34, 3'b010, 16'h0000);
      add(0, OP_I,  16'h0000, 16'h0000, 16'hBE34, 3'b000, 16'h0000);
      add(0, OP_R,  16'h0010, 16'h0000, 16'hBE34, 3'b100, 16'h0000);
      add(0, OP_I,  16'h0000, 16'h0000, 16'hBE34, 3'b000, 16'h0000);
      add(0, OP_W,  16'h0050, 16'hAAAA, 16'hBE34, 3'b010, 16'h0000);
      add(0, OP_W,  16'h0010, 16'hAAAA, 16'hBE34, 3'b000, 16'h0000);
      add(0, OP_I,  16'h0000, 16'h0000, 16'hBE34, 3'b000, 16'h0000);
      add(0, OP_R,  16'h0050, 16'h0000, 16'h0505, 3'b100, 16'h0000);
      add(0, OP_I,  16'h0000, 16'h0000, 16'h0505, 3'b000, 16'h0000);
      add(0, OP_R,  16'h0010, 16'h0000, 16'hBE34, 3'b100, 16'h0000);
      add(0, OP_I,  16'h0000, 16'h0000, 16'hBE34, 3'b000, 16'h0000);
      add(0, OP_W,  16'h0040, 16'h4444, 16'hBE34, 3'b010, 16'h0000);
      add(0, OP_W,  16'h0040, 16'h4444, 16'hBE34, 3'b000, 16'h0000);
      add(0, OP_W,  16'h0040, 16'h5555, 16'hBE34, 3'b000, 16'h0000);
      add(0, OP_W,  16'h0040, 16'h5555, 16'hBE34, 3'b000, 16'h0000);
      add(0, OP_I,  16'h0000, 16'h0000, 16'hBE34, 3'b000, 16'h0000);
      add(0, OP_R,  16'h0040, 16'h0000, 16'h4444, 3'b100, 16'h0000);
      add(0, OP_I,  16'h0000, 16'h0000, 16'h4444, 3'b000, 16'h0000);
      add(0, OP_R,  16'hFFFF, 16'h0000, 16'h00A5, 3'b100, 16'h0000);
      add(0, OP_I,  16'h0000, 16'h0000, 16'h00A5, 3'b000, 16'h0000);
      add(0, OP_W,  16'hFFFF, 16'h0C0D, 16'h00A5, 3'b010, 16'h0000);
      add(0, OP_W,  16'hFFFF, 16'h0C0D, 16'h00A5, 3'b000, 16'h0C0D);
      add(0, OP_I,  16'h0000, 16'h0000, 16'h00A5, 3'b000, 16'h0C0D);
      add(0, OP_R,  16'h03FF, 16'h0000, 16'h5A5A, 3'b100, 16'h0C0D);
      add(0, OP_I,  16'h0000, 16'h0000, 16'h5A5A, 3'b000, 16'h0C0D);
      add(0, OP_WL, 16'hFFFF, 16'h1234, 16'h5A5A, 3'b010, 16'h0C0D);
      add(0, OP_WL, 16'hFFFF, 16'h1234, 16'h5A5A, 3'b000, 16'h0C34);
      add(0, OP_I,  16'h0000, 16'h0000, 16'h5A5A, 3'b000, 16'h0C34);
      add(0, OP_W,  16'h0020, 16'h2222, 16'h5A5A, 3'b010, 16'h0C34);
      add(0, OP_B,  16'h0020, 16'h2222, 16'h5A5A, 3'b001, 16'h0C34);
      add(0, OP_B,  16'h0020, 16'h2222, 16'h5A5A, 3'b001, 16'h0C34);
      add(0, OP_B,  16'h0020, 16'h2222, 16'h5A5A, 3'b001, 16'h0C34);
      add(0, OP_I,  16'h0000, 16'h0000, 16'h5A5A, 3'b000, 16'h0C34);
      add(0, OP_R,  16'h0020, 16'h0000, 16'h1111, 3'b100, 16'h0C34);
      add(0, OP_I,  16'h0000, 16'h0000, 16'h1111, 3'b000, 16'h0C34);
      add(0, OP_R,  16'h0410, 16'h0000, 16'hBE34, 3'b100, 16'h0C34);
      add(0, OP_I,  16'h0000, 16'h0000, 16'hBE34, 3'b000, 16'h0C34);
      add(0, OP_R,  16'h0030, 16'h0000, 16'h3030, 3'b100, 16'h0C34);
      add(0, OP_B,  16'h0030, 16'h0000, 16'h3030, 3'b001, 16'h0C34);
      add(0, OP_I,  16'h0000, 16'h0000, 16'h3030, 3'b000, 16'h0C34);
      add(0, OP_W,  16'h0030, 16'hFFFF, 16'h3030, 3'b010, 16'h0C34);
      add(1, OP_W,  16'h0030, 16'hFFFF, 16'h0000, 3'b000, 16'h0000);
      add(0, OP_I,  16'h0000, 16'h0000, 16'h0000, 3'b000, 16'h0000);
      add(0, OP_R,  16'h0030, 16'h0000, 16'h3030, 3'b100, 16'h0000);
      add(0, OP_I,  16'h0000, 16'h0000, 16'h3030, 3'b000, 16'h0000);
      for (int i = 0; i < tv.size(); i++) begin
         step(tv[i].rst, tv[i].op, tv[i].a, tv[i].d);
         check($sformatf("v%0d Data_from_SRAM", i), bus.Data_from_SRAM, tv[i].e_rd);
         check($sformatf("v%0d Data_valid", i), {15'd0, bus.Data_valid}, {15'd0, tv[i].e_vbe[2]});
         check($sformatf("v%0d Busy", i), {15'd0, bus.Busy}, {15'd0, tv[i].e_vbe[1]});
         check($sformatf("v%0d Err", i), {15'd0, bus.Err}, {15'd0, tv[i].e_vbe[0]});
         check($sformatf("v%0d HEX_out", i), bus.HEX_out, tv[i].e_hex);
      end
      // ISDU fetch: S_18 MAR<-PC, S_33_1/S_33_2 OE low, MDR loads at end of S_33_2, S_35 IR<-MDR
      step(0, OP_I, 16'h0010, 16'h0000);
      step(0, OP_R, 16'h0010, 16'h0000);
      mdr = bus.Data_from_SRAM;
      step(0, OP_R, 16'h0010, 16'h0000);
      step(0, OP_I, 16'h0000, 16'h0000);
      ir = mdr;
      check("fetch IR", ir, 16'hBE34);
      // RD_LAT=3 / WR_LAT=1 instance
      step(0, OP_W, 16'h0060, 16'h6060);
      check("lat31 wr1 Busy", {15'd0, bus2.Busy}, 16'h0000);
      step(0, OP_I, 16'h0000, 16'h0000);
      step(0, OP_W, 16'h0070, 16'h7070);
      step(0, OP_I, 16'h0000, 16'h0000);
      step(0, OP_R, 16'h0060, 16'h0000);
      check("lat31 rd1 Busy", {15'd0, bus2.Busy}, 16'h0001);
      check("lat31 rd1 Data_valid", {15'd0, bus2.Data_valid}, 16'h0000);
      step(0, OP_I, 16'h0000, 16'h0000);
      check("lat31 short rd Data_valid", {15'd0, bus2.Data_valid}, 16'h0000);
      check("lat31 short rd Busy", {15'd0, bus2.Busy}, 16'h0000);
      step(0, OP_R, 16'h0060, 16'h0000);
      step(0, OP_R, 16'h0060, 16'h0000);
      check("lat31 rd2 Data_from_SRAM", bus2.Data_from_SRAM, 16'h6060);
      check("lat31 rd2 Data_valid", {15'd0, bus2.Data_valid}, 16'h0001);
      step(0, OP_I, 16'h0000, 16'h0000);
      step(0, OP_R, 16'h0060, 16'h0000);
      step(0, OP_R, 16'h0070, 16'h0000);
      check("lat31 restart Busy", {15'd0, bus2.Busy}, 16'h0001);
      check("lat31 restart Data_valid", {15'd0, bus2.Data_valid}, 16'h0000);
      step(0, OP_R, 16'h0070, 16'h0000);
      check("lat31 restart Data_from_SRAM", bus2.Data_from_SRAM, 16'h7070);
      check("lat31 restart Data_valid2", {15'd0, bus2.Data_valid}, 16'h0001);
      step(0, OP_I, 16'h0000, 16'h0000);
      check("lat31 drop Data_valid", {15'd0, bus2.Data_valid}, 16'h0000);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
